tc_pl_cap_gain_arb: RTL
=======================

Name: tc_pl_cap_gain_arb

Overview:
- Arbiter/sequencer in front of the FDA gain-set path (the gain_lmh tx + SPI pair).
- Shares the single gain-write channel between two requesters: PS register writes (ps) and the automatic gain loop (agc).
- Issues one gset_en pulse per granted request, waits for gset_lmh_cmpt, and acknowledges the owner.
- Also tracks the currently programmed gain code, suppresses redundant writes, and guards against a hung SPI transfer with a timeout.

Parameters:
CAP0_13, 6, width of gain code (matches downstream gset_lmh)
TMO_CYC, 65535, max clk cycles spent in WAIT before timeout (1..65535)
SKIP_SAME, 1, 1 = request equal to cur_gain while cur_valid=1 completes without an SPI write

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
ps_req  in  1  PS request; held high, ps_gain stable, until ps_ack
ps_gain  in  CAP0_13  PS requested gain code
ps_ack  out  1  1-cycle completion pulse to PS
agc_req  in  1  AGC request; same rules as ps_req
agc_gain  in  CAP0_13  AGC requested gain code
agc_ack  out  1  1-cycle completion pulse to AGC
gset_en  out  1  1-cycle start pulse to gain-set path
gset_lmh  out  CAP0_13  code to downstream; registered, stable from gset_en until cmpt
gset_lmh_cmpt  in  1  downstream completion (pulse or level)
cur_gain  out  CAP0_13  last successfully written code
cur_valid  out  1  cur_gain reflects hardware
busy  out  1  high in any state other than IDLE
tmo_err  out  1  sticky timeout flag
err_clr  in  1  clears tmo_err (rst also clears)

Behaviour:
- Reset values: ps_ack=0, agc_ack=0, gset_en=0, gset_lmh=0, cur_gain=0, cur_valid=0, busy=0, tmo_err=0, state=IDLE, last_grant=AGC (so PS wins the first contention), timeout counter=0.
- States:
  - IDLE: sample requests.
    - Only one req high: grant it.
    - Both high: grant the requester not equal to last_grant (round-robin).
    - Latch the granted code into gset_lmh and update last_grant.
    - If SKIP_SAME=1, cur_valid=1 and code==cur_gain -> DONE; otherwise -> ISSUE.
  - ISSUE: gset_en=1 for exactly this cycle; clear timeout counter -> WAIT.
  - WAIT: count cycles.
    - First cycle with gset_lmh_cmpt=1 -> DONE with success; cur_gain<=gset_lmh, cur_valid<=1.
    - Counter reaching TMO_CYC with no cmpt -> DONE with failure; tmo_err<=1, cur_valid<=0.
  - DONE: pulse the granted requester's ack for 1 cycle -> IDLE. In this cycle the granted requester's req is ignored, since the requester drops it on seeing ack.
- Latency, with req seen in IDLE at cycle N:
  - gset_en at N+1.
  - cmpt at cycle M>=N+2 -> ack at M+1; IDLE at M+2.
  - Skip path: ack at N+1, no gset_en.
  - Timeout: ack at N+2+TMO_CYC.
- Back-to-back: the earliest next grant is sampled in the IDLE cycle following DONE, giving at most one transfer per 4+ cycles.
- A pending losing requester is granted next, guaranteeing no starvation.
- gset_lmh_cmpt outside WAIT is ignored. A level cmpt held high is acted on once.
- Requester changes gain while req is high: not supported; the latched code is used.
- Requester drops req before ack: the transaction still completes and its ack still pulses.
- err_clr in the same cycle as a timeout: set wins. err_clr does not affect state or cur_valid.
- Reset mid-transfer (any state): immediate return to reset values next cycle, no ack issued. The downstream shares rst and aborts as well.

Test Plan:
- Single PS write: ps_req=1, ps_gain=6'h15, cmpt 40 cycles after gset_en -> one gset_en with gset_lmh=6'h15; ps_ack 1 cycle after cmpt; cur_gain=6'h15, cur_valid=1; agc_ack never asserts.
- Contention: ps_req and agc_req both high in the same cycle from reset (codes 6'h01/6'h02) -> PS served first (gset_lmh=6'h01), then AGC (6'h02); repeat with both pending after AGC -> PS next; exactly two gset_en per pair.
- Redundant skip: after cur_gain=6'h15 valid, agc_req with 6'h15 -> agc_ack at N+1, no gset_en; with SKIP_SAME=0 build -> full write occurs.
- Timeout: TMO_CYC=16, cmpt never asserted -> ack at N+18, tmo_err=1, cur_valid=0; next request proceeds normally; err_clr pulse -> tmo_err=0.
- Stray/level cmpt: cmpt pulsed in IDLE -> no effect; cmpt held high for 10 cycles in WAIT -> single ack, single update.
- Reset mid-WAIT: rst for 1 cycle during WAIT -> next cycle busy=0, no ack, cur_valid=0, gset_en=0; subsequent request completes normally.

Source files
------------

// File: rtl/tc_pl_cap_gain_arb.sv
// Gain-write arbiter: shares the single gain-set channel between PS and AGC
// requesters, sequences one gset_en/cmpt handshake per grant, tracks the live code.
module tc_pl_cap_gain_arb #(
  parameter int CAP0_13   = 6,
  parameter int TMO_CYC   = 65535,
  parameter bit SKIP_SAME = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps_req,
  input  logic [CAP0_13-1:0] ps_gain,
  output logic               ps_ack,
  input  logic               agc_req,
  input  logic [CAP0_13-1:0] agc_gain,
  output logic               agc_ack,
  output logic               gset_en,
  output logic [CAP0_13-1:0] gset_lmh,
  input  logic               gset_lmh_cmpt,
  output logic [CAP0_13-1:0] cur_gain,
  output logic               cur_valid,
  output logic               busy,
  output logic               tmo_err,
  input  logic               err_clr
);

  localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               gnt_agc_q, gnt_agc_d;   // owner of the current/last grant
  logic [CAP0_13-1:0] gset_lmh_q, gset_lmh_d;
  logic [CAP0_13-1:0] cur_gain_q, cur_gain_d;
  logic               cur_valid_q, cur_valid_d;
  logic               tmo_err_q, tmo_err_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tmo_set;
  logic               pick_agc;
  logic [CAP0_13-1:0] pick_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_agc_q   <= 1'b1;
      gset_lmh_q  <= '0;
      cur_gain_q  <= '0;
      cur_valid_q <= 1'b0;
      tmo_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_agc_q   <= gnt_agc_d;
      gset_lmh_q  <= gset_lmh_d;
      cur_gain_q  <= cur_gain_d;
      cur_valid_q <= cur_valid_d;
      tmo_err_q   <= tmo_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_agc_d   = gnt_agc_q;
    gset_lmh_d  = gset_lmh_q;
    cur_gain_d  = cur_gain_q;
    cur_valid_d = cur_valid_q;
    cnt_d       = cnt_q;
    tmo_set     = 1'b0;
    // On contention the side that did not win last time gets the channel.
    pick_agc    = agc_req && (!ps_req || !gnt_agc_q);
    pick_code   = pick_agc ? agc_gain : ps_gain;
    unique case (state_q)
      S_IDLE: begin
        if (ps_req || agc_req) begin
          gnt_agc_d  = pick_agc;
          gset_lmh_d = pick_code;
          if (SKIP_SAME && cur_valid_q && (pick_code == cur_gain_q)) state_d = S_DONE;
          else                                                       state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gset_lmh_cmpt) begin
          cur_gain_d  = gset_lmh_q;
          cur_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (cnt_q == CW'(TMO_CYC - 1)) begin
          tmo_set     = 1'b1;
          cur_valid_d = 1'b0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A timeout in the same cycle as err_clr keeps the flag set.
    tmo_err_d = tmo_set ? 1'b1 : (err_clr ? 1'b0 : tmo_err_q);
  end

  assign gset_en   = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign ps_ack    = (state_q == S_DONE) && !gnt_agc_q;
  assign agc_ack   = (state_q == S_DONE) &&  gnt_agc_q;
  assign gset_lmh  = gset_lmh_q;
  assign cur_gain  = cur_gain_q;
  assign cur_valid = cur_valid_q;
  assign tmo_err   = tmo_err_q;

endmodule
